// File: rtl/mem_pkg.sv
// Shared types and limits for the data-memory responder.
package mem_pkg;

    localparam int LATENCY_MAX = 15;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Request/response views for the default core configuration.
    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_W-1:0]     addr;
        logic [DMEM_DATA_W-1:0]     wdata;
        logic [DMEM_DATA_W/8-1:0]   be;
    } dmem_req_t;

    typedef struct packed {
        logic [DMEM_DATA_W-1:0]     rdata;
        logic                       err;
    } dmem_resp_t;

    function automatic logic [3:0] wcnt_load(input int latency);
        return 4'(latency - 1);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with byte-enabled synchronous write and registered read.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 200,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; callers guard addr against DEPTH.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states,
// byte-enabled write or read, single-cycle response, abort while waiting.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states; access happens when wcnt reaches 0
// RESP  | resp_valid high for one cycle
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 200,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic                abort,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                busy
);

    localparam int BE_W = DATA_W/8;
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;
    localparam logic [3:0] WCNT_LOAD = wcnt_load(LATENCY);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state;
    logic [3:0]        wcnt;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [BE_W-1:0]   cap_be;
    logic              err_q;
    logic              rd_q;

    logic              in_range;
    logic              access;
    logic [DATA_W-1:0] arr_rdata;

    assign in_range = ({1'b0, cap_addr} < DEPTH_L);
    // Abort on the final wait cycle must still suppress the access.
    assign access   = (state == ST_WAIT) && (wcnt == 4'd0) && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wcnt      <= 4'd0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_be    <= req_be;
                        wcnt      <= WCNT_LOAD;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        wcnt  <= 4'd0;
                        state <= ST_IDLE;
                    end else if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        err_q <= !in_range;
                        rd_q  <= !cap_we && in_range;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    err_q <= 1'b0;
                    rd_q  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    wcnt  <= 4'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .wr_en (access && cap_we && in_range),
        .rd_en (access && !cap_we && in_range),
        .addr  (cap_addr),
        .wdata (cap_wdata),
        .be    (cap_be),
        .rdata (arr_rdata)
    );

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_err   = (state == ST_RESP) && err_q;
    // Array read register is unreset, so only expose it for a valid read response.
    assign resp_rdata = ((state == ST_RESP) && rd_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases plus randomized traffic
// checked against an array-based reference memory.
module tb_dmem_responder;

    localparam int DW    = 16;
    localparam int DEPTH = 200;
    localparam int AW    = 8;
    localparam int LAT   = 4;
    localparam int BW    = DW/8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [BW-1:0] req_be = '0;
    logic          abort = 1'b0;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;
    logic          resp_err;
    logic          busy;

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW),
        .LATENCY(LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .abort      (abort),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int b = 0; b < BW; b++)
            if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                check("resp_err",   32'(resp_err),   32'(e.err));
                check("resp_cycle", 32'(cyc),        32'(e.cyc));
            end
        end
    end

    // abort_at = k asserts abort so that it is sampled at edge T+k (T = acceptance).
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be,
                         input int abort_at, output int acc);
        int   w;
        bit   aborted;
        bit   in_rng;
        exp_t e;
        w = 0;
        acc = -1;
        @(negedge clk);
        while (!req_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        @(posedge clk);
        #1;
        acc     = cyc;
        aborted = (abort_at >= 1) && (abort_at <= LAT);
        in_rng  = (int'(addr) < DEPTH);
        if (!aborted) begin
            e.err   = !in_rng;
            e.cyc   = acc + LAT;
            e.rdata = (!we && in_rng) ? ref_mem[addr] : '0;
            if (we && in_rng) ref_mem[addr] = merge(ref_mem[addr], wd, be);
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = DW'($urandom);
        req_addr  = AW'($urandom);
        if (abort_at >= 1) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            if (aborted) begin
                check("abort_ready", 32'(req_ready),  32'd1);
                check("abort_busy",  32'(busy),       32'd0);
                check("abort_nresp", 32'(resp_valid), 32'd0);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready),  32'd1);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_rdata"}, 32'(resp_rdata), 32'd0);
        check({tag, "_err"},   32'(resp_err),   32'd0);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 50) begin
            w++;
            @(negedge clk);
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d responses outstanding", sb.size());
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2;
        // Reset defaults
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++)
            issue(1'b1, AW'(i), DW'($urandom), '1, 0, a1);
        drain();

        // Write then read, with acceptance spacing
        issue(1'b1, 8'h10, 16'hBEEF, 2'b11, 0, a1);
        issue(1'b0, 8'h10, 16'h0000, 2'b00, 0, a2);
        check("spacing", 32'(a2 - a1), 32'(LAT + 2));
        check("model_beef", 32'(ref_mem[8'h10]), 32'hBEEF);

        // Byte-lane writes
        issue(1'b1, 8'h03, 16'hBEEF, 2'b11, 0, a1);
        issue(1'b1, 8'h03, 16'h1234, 2'b01, 0, a1);
        issue(1'b0, 8'h03, 16'h0000, 2'b00, 0, a1);
        issue(1'b1, 8'h03, 16'h5555, 2'b00, 0, a1);
        issue(1'b0, 8'h03, 16'h0000, 2'b00, 0, a1);
        check("model_be34", 32'(ref_mem[3]), 32'hBE34);

        // Out of range
        issue(1'b1, 8'hC8, 16'hAAAA, 2'b11, 0, a1);
        issue(1'b0, 8'hC8, 16'h0000, 2'b00, 0, a1);
        issue(1'b0, 8'hC7, 16'h0000, 2'b00, 0, a1);

        // Abort in second wait cycle, then on the final wait cycle
        issue(1'b1, 8'h05, 16'hDEAD, 2'b11, 2, a1);
        issue(1'b0, 8'h05, 16'h0000, 2'b00, 0, a1);
        issue(1'b1, 8'h05, 16'hF00D, 2'b11, LAT, a1);
        issue(1'b0, 8'h05, 16'h0000, 2'b00, 0, a1);
        // Abort during RESP is ignored
        issue(1'b1, 8'h05, 16'h0C0C, 2'b11, LAT + 1, a1);
        issue(1'b0, 8'h05, 16'h0000, 2'b00, 0, a1);
        drain();

        // Reset mid-access
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 8'h07;
        req_wdata = ~ref_mem[7];
        req_be    = 2'b11;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 8'h07, 16'h0000, 2'b00, 0, a1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic          we;
            logic [AW-1:0] ad;
            int            ab;
            we = 1'($urandom_range(0, 1));
            ad = AW'($urandom_range(0, 209));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT + 1)) : 0;
            issue(we, ad, DW'($urandom), BW'($urandom), ab, a1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 7) == 0 && req_ready) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the three-stage core: the memory-side end of the load/store traffic that stage three issues. Accepts one request at a time over a valid/ready handshake, inserts a programmable number of wait states, performs a byte-enabled write or a read, and returns a single-cycle response pulse. `busy` lets the pipeline stall. `abort` lets the core drop an in-flight access on halt.

## Interface
- `DATA_W`, default 16: data word width; must be a multiple of 8.
- `DEPTH`, default 200: number of words implemented; legal addresses are 0..DEPTH-1.
- `ADDR_W`, default 8: word-address width; DEPTH ≤ 2^ADDR_W.
- `LATENCY`, default 2: wait states between acceptance and access; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `req_be` in DATA_W/8: byte enables for writes; ignored for reads.
- `abort` in 1: cancel the in-flight access.
- `resp_valid` out 1: one-cycle response strobe.
- `resp_rdata` out DATA_W: read data, valid with `resp_valid`; 0 for writes and errors.
- `resp_err` out 1: address out of range, valid with `resp_valid`.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready` = 1.
  - When `req_valid` is high, capture we, addr, wdata and be. Load `wcnt` = LATENCY-1 and go to WAIT.
- **WAIT**
  - `req_ready` = 0.
  - While `wcnt` ≠ 0, decrement it.
  - When `wcnt` = 0, perform the access and go to RESP:
    - Write: update the enabled byte lanes only.
    - Read: register the array word into `resp_rdata`.
- **Range check:** when addr ≥ DEPTH, no array write occurs, `resp_rdata` = 0 and `resp_err` = 1.
- **RESP**
  - `resp_valid` = 1 for exactly one cycle, then return to IDLE.
  - There is no response back-pressure.
- **Abort**
  - `abort` high in WAIT returns to IDLE next cycle. No write occurs and no response is issued.
  - `abort` in IDLE or RESP is ignored.
  - `abort` and the final WAIT cycle (`wcnt` = 0) together: abort wins and the write is suppressed.
- **Write with `req_be` = 0:** completes normally with a response; memory is unchanged.
- **Ordering:** a read following a write to the same address returns the new data; accesses are strictly sequential.
- **Reset:**
  - State = IDLE, `wcnt` = 0.
  - `req_ready` = 1, `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `busy` = 0.
  - Array contents are not reset.
  - Reset asserted mid-access discards the access; a partially counted write never reaches the array.

## Timing
- Request accepted at edge T (`req_valid` and `req_ready` both high).
- Access occurs at edge T+LATENCY.
- `resp_valid` is high during the cycle after edge T+LATENCY, from T+LATENCY to T+LATENCY+1.
- `req_ready` rises again after edge T+LATENCY+1.
- Minimum request spacing: LATENCY+2 cycles.
- `req_ready` and `busy` are registered-state decodes with no combinational path from `req_valid`.
- All outputs are registered or state-decoded; there are no input-to-output combinational paths.

## Structure
- Shared package `mem_pkg` holds:
  - `dmem_state_e` (IDLE, WAIT, RESP).
  - `dmem_req_t` struct (we, addr, wdata, be).
  - `dmem_resp_t` struct (rdata, err).
  - `LATENCY_MAX` = 15.
- Sub-module `dmem_array`: DEPTH×DATA_W storage with synchronous byte-enabled write and synchronous read, one port.
- The top FSM, wait counter, capture register and range check live in `dmem_responder`.

## Test plan
- **Reset defaults:** hold `rst` low 3 cycles, release → `req_ready`=1, `busy`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- **Write then read, LATENCY=2:**
  - Write addr 0x10, data 0xBEEF, be=11, accepted at cycle 5 → `resp_valid` during cycle 7→8.
  - Read addr 0x10 → `resp_rdata`=0xBEEF, `resp_err`=0.
  - Spacing between acceptances is exactly 4 cycles.
- **Byte-lane write:**
  - Preload 0xBEEF at addr 3.
  - Write 0x1234 with be=01 → a following read returns 0xBE34.
  - Write with be=00 → memory unchanged, response still issued.
- **Out of range, DEPTH=200:**
  - Write addr 0xC8 → `resp_err`=1 and no array change.
  - Read 0xC8 → `resp_rdata`=0, `resp_err`=1.
  - Read 0xC7 → `resp_err`=0.
- **Abort:**
  - LATENCY=4 write to addr 5, `abort` pulsed in the second WAIT cycle → no `resp_valid`; IDLE and `req_ready`=1 next cycle; a later read of addr 5 returns the old value.
  - Repeat with `abort` coinciding with the final WAIT cycle → same result.
- **Reset mid-access:** assert `rst` while a write to addr 7 is in WAIT → all outputs return to their reset values immediately and addr 7 is unchanged after the reset.
